// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle main controller: opcodes, functs,
// FSM state codes, datapath mux/ALU/NPC codes and the decoded class record.
package mc_defs;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_DCD   = 3'd1,
    S_EXE   = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGEZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_31  = 2'b10;

  localparam logic [1:0] WDSEL_ALU  = 2'b00;
  localparam logic [1:0] WDSEL_DM   = 2'b01;
  localparam logic [1:0] WDSEL_PC   = 2'b10;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_LUI    = 2'b10;

  // Must track the existing ALU and NPC unit encodings.
  localparam logic [1:0] ALU_ADDU   = 2'b00;
  localparam logic [1:0] ALU_SUBU   = 2'b01;
  localparam logic [1:0] ALU_OR     = 2'b10;

  localparam logic [2:0] NPC_PC4    = 3'b000;
  localparam logic [2:0] NPC_BEQ    = 3'b001;
  localparam logic [2:0] NPC_J      = 3'b010;
  localparam logic [2:0] NPC_JR     = 3'b011;
  localparam logic [2:0] NPC_BGEZ   = 3'b100;

  typedef struct packed {
    logic r_addu;
    logic r_subu;
    logic r_jr;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic bgez;
    logic j;
    logic jal;
    logic illegal;
  } iclass_t;

  // Classes that finish in DCD without visiting EXE.
  function automatic logic ends_in_dcd(input iclass_t c);
    return c.j | c.jal | c.r_jr | c.illegal;
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational op/funct decoder producing a one-hot instruction class.
module mc_decode
  import mc_defs::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output iclass_t    iclass
);

  // One-hot classification; anything unrecognised becomes illegal.
  always_comb begin
    iclass = '0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: iclass.r_addu  = 1'b1;
          FN_SUBU: iclass.r_subu  = 1'b1;
          FN_JR:   iclass.r_jr    = 1'b1;
          default: iclass.illegal = 1'b1;
        endcase
      end
      OP_ORI:  iclass.ori     = 1'b1;
      OP_LUI:  iclass.lui     = 1'b1;
      OP_LW:   iclass.lw      = 1'b1;
      OP_SW:   iclass.sw      = 1'b1;
      OP_BEQ:  iclass.beq     = 1'b1;
      OP_BGEZ: iclass.bgez    = 1'b1;
      OP_J:    iclass.j       = 1'b1;
      OP_JAL:  iclass.jal     = 1'b1;
      default: iclass.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: FETCH/DCD/EXE/MEM/WB state machine driving the
// datapath write enables and mux/ALU/NPC select codes.
module mc_ctrl
  import mc_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RFWr,
  output logic       DMWr,
  output logic [1:0] RegDst,
  output logic [1:0] WDSel,
  output logic       ALUSrc,
  output logic [1:0] EXTOp,
  output logic [1:0] ALUctr,
  output logic [2:0] nPC_sel,
  output logic [2:0] state,
  output logic       done
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  iclass_t    cls_s;

  logic       alu_src_s;
  logic [1:0] ext_op_s;
  logic [1:0] alu_ctr_s;

  mc_decode u_decode (
    .op     (op),
    .funct  (funct),
    .iclass (cls_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; unused codes fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DCD;
      S_DCD: begin
        if (ends_in_dcd(cls_s)) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        if (cls_s.beq | cls_s.bgez) begin
          state_d = S_FETCH;
        end else if (cls_s.lw | cls_s.sw) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (cls_s.lw) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // ALU operand setup held through EXE, MEM and WB of each class.
  always_comb begin
    alu_src_s = cls_s.ori | cls_s.lui | cls_s.lw | cls_s.sw;
    if (cls_s.lw | cls_s.sw) begin
      ext_op_s = EXT_SIGN;
    end else if (cls_s.lui) begin
      ext_op_s = EXT_LUI;
    end else begin
      ext_op_s = EXT_ZERO;
    end
    if (cls_s.r_subu | cls_s.beq) begin
      alu_ctr_s = ALU_SUBU;
    end else if (cls_s.ori | cls_s.lui) begin
      alu_ctr_s = ALU_OR;
    end else begin
      alu_ctr_s = ALU_ADDU;
    end
  end

  // Output logic; reset masks everything so an aborted instruction writes nothing.
  always_comb begin
    PCWr    = 1'b0;
    IRWr    = 1'b0;
    RFWr    = 1'b0;
    DMWr    = 1'b0;
    RegDst  = REGDST_RT;
    WDSel   = WDSEL_ALU;
    ALUSrc  = 1'b0;
    EXTOp   = EXT_ZERO;
    ALUctr  = ALU_ADDU;
    nPC_sel = NPC_PC4;
    done    = 1'b0;
    if (reset) begin
      done = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        S_DCD: begin
          done = ends_in_dcd(cls_s);
          if (cls_s.j | cls_s.jal) begin
            PCWr    = 1'b1;
            nPC_sel = NPC_J;
          end else if (cls_s.r_jr) begin
            PCWr    = 1'b1;
            nPC_sel = NPC_JR;
          end else begin
            PCWr    = 1'b0;
          end
          if (cls_s.jal) begin
            RFWr   = 1'b1;
            RegDst = REGDST_31;
            WDSel  = WDSEL_PC;
          end else begin
            RFWr   = 1'b0;
          end
        end
        S_EXE: begin
          ALUSrc = alu_src_s;
          EXTOp  = ext_op_s;
          ALUctr = alu_ctr_s;
          if (cls_s.beq) begin
            nPC_sel = NPC_BEQ;
            PCWr    = zero;
            done    = 1'b1;
          end else if (cls_s.bgez) begin
            nPC_sel = NPC_BGEZ;
            PCWr    = zero;
            done    = 1'b1;
          end else begin
            PCWr    = 1'b0;
          end
        end
        S_MEM: begin
          ALUSrc = alu_src_s;
          EXTOp  = ext_op_s;
          ALUctr = alu_ctr_s;
          DMWr   = cls_s.sw;
          done   = cls_s.sw;
        end
        S_WB: begin
          ALUSrc = alu_src_s;
          EXTOp  = ext_op_s;
          ALUctr = alu_ctr_s;
          RFWr   = 1'b1;
          done   = 1'b1;
          if (cls_s.lw) begin
            WDSel  = WDSEL_DM;
            RegDst = REGDST_RT;
          end else if (cls_s.r_addu | cls_s.r_subu) begin
            WDSel  = WDSEL_ALU;
            RegDst = REGDST_RD;
          end else begin
            WDSel  = WDSEL_ALU;
            RegDst = REGDST_RT;
          end
        end
        default: done = 1'b0;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle vector table of instruction
// sequences plus a hand-written reset-abort sequence.
module tb_mc_ctrl;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       PCWr, IRWr, RFWr, DMWr, ALUSrc, done;
  logic [1:0] RegDst, WDSel, EXTOp, ALUctr;
  logic [2:0] nPC_sel, state;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [19:0] exp;
  } vec_t;

  vec_t vecs[$];

  mc_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .funct   (funct),
    .zero    (zero),
    .PCWr    (PCWr),
    .IRWr    (IRWr),
    .RFWr    (RFWr),
    .DMWr    (DMWr),
    .RegDst  (RegDst),
    .WDSel   (WDSel),
    .ALUSrc  (ALUSrc),
    .EXTOp   (EXTOp),
    .ALUctr  (ALUctr),
    .nPC_sel (nPC_sel),
    .state   (state),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packing order: state, PCWr, IRWr, RFWr, DMWr, RegDst, WDSel, ALUSrc, EXTOp, ALUctr, nPC_sel, done
  function automatic logic [19:0] e(input logic [2:0] s, input logic pc, input logic ir,
                                    input logic rf, input logic dm, input logic [1:0] rd,
                                    input logic [1:0] wd, input logic as, input logic [1:0] ext,
                                    input logic [1:0] alu, input logic [2:0] npc, input logic dn);
    return {s, pc, ir, rf, dm, rd, wd, as, ext, alu, npc, dn};
  endfunction

  task automatic chk(input string name, input logic [19:0] exp);
    logic [19:0] act;
    act = {state, PCWr, IRWr, RFWr, DMWr, RegDst, WDSel, ALUSrc, EXTOp, ALUctr, nPC_sel, done};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h, expected %05h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [19:0] x);
    vec_t v;
    v.name = name; v.op = o; v.funct = f; v.zero = z; v.exp = x;
    vecs.push_back(v);
  endtask

  task automatic apply(input string name, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic [19:0] x);
    op = o; funct = f; zero = z;
    #1;
    chk(name, x);
    @(posedge clk);
    #1;
  endtask

  logic [19:0] fe, dc, zr;

  initial begin
    fe = e(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0);
    dc = e(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0);
    zr = e(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0);

    // addu
    add("addu_f", 6'h00, 6'h21, 1'b0, fe);
    add("addu_d", 6'h00, 6'h21, 1'b0, dc);
    add("addu_e", 6'h00, 6'h21, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0));
    add("addu_w", 6'h00, 6'h21, 1'b0, e(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1));
    // subu
    add("subu_f", 6'h00, 6'h23, 1'b0, fe);
    add("subu_d", 6'h00, 6'h23, 1'b0, dc);
    add("subu_e", 6'h00, 6'h23, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 3'b000, 1'b0));
    add("subu_w", 6'h00, 6'h23, 1'b0, e(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b01, 3'b000, 1'b1));
    // ori
    add("ori_f", 6'h0d, 6'h00, 1'b0, fe);
    add("ori_d", 6'h0d, 6'h00, 1'b0, dc);
    add("ori_e", 6'h0d, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 3'b000, 1'b0));
    add("ori_w", 6'h0d, 6'h00, 1'b0, e(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 2'b10, 3'b000, 1'b1));
    // lui
    add("lui_f", 6'h0f, 6'h00, 1'b0, fe);
    add("lui_d", 6'h0f, 6'h00, 1'b0, dc);
    add("lui_e", 6'h0f, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 3'b000, 1'b0));
    add("lui_w", 6'h0f, 6'h00, 1'b0, e(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 3'b000, 1'b1));
    // lw: 5 cycles
    add("lw_f", 6'h23, 6'h00, 1'b0, fe);
    add("lw_d", 6'h23, 6'h00, 1'b0, dc);
    add("lw_e", 6'h23, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0));
    add("lw_m", 6'h23, 6'h00, 1'b0, e(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0));
    add("lw_w", 6'h23, 6'h00, 1'b0, e(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 2'b01, 2'b00, 3'b000, 1'b1));
    // sw: 4 cycles, DMWr only in MEM
    add("sw_f", 6'h2b, 6'h00, 1'b0, fe);
    add("sw_d", 6'h2b, 6'h00, 1'b0, dc);
    add("sw_e", 6'h2b, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0));
    add("sw_m", 6'h2b, 6'h00, 1'b0, e(3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b1));
    // beq taken
    add("beq1_f", 6'h04, 6'h00, 1'b0, fe);
    add("beq1_d", 6'h04, 6'h00, 1'b0, dc);
    add("beq1_e", 6'h04, 6'h00, 1'b1, e(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 3'b001, 1'b1));
    // beq not taken, zero high outside EXE must not matter
    add("beq0_f", 6'h04, 6'h00, 1'b1, fe);
    add("beq0_d", 6'h04, 6'h00, 1'b1, dc);
    add("beq0_e", 6'h04, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b01, 3'b001, 1'b1));
    // bgez taken / not taken
    add("bgez1_f", 6'h01, 6'h00, 1'b0, fe);
    add("bgez1_d", 6'h01, 6'h00, 1'b0, dc);
    add("bgez1_e", 6'h01, 6'h00, 1'b1, e(3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b100, 1'b1));
    add("bgez0_f", 6'h01, 6'h00, 1'b0, fe);
    add("bgez0_d", 6'h01, 6'h00, 1'b0, dc);
    add("bgez0_e", 6'h01, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b100, 1'b1));
    // j, jal, jr: 2 cycles
    add("j_f", 6'h02, 6'h00, 1'b0, fe);
    add("j_d", 6'h02, 6'h00, 1'b0, e(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1));
    add("jal_f", 6'h03, 6'h00, 1'b0, fe);
    add("jal_d", 6'h03, 6'h00, 1'b0, e(3'd1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 2'b00, 3'b010, 1'b1));
    add("jr_f", 6'h00, 6'h08, 1'b0, fe);
    add("jr_d", 6'h00, 6'h08, 1'b0, e(3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b011, 1'b1));
    // illegal op and unknown R-type funct: nop finishing in DCD
    add("ill_f", 6'h3f, 6'h00, 1'b0, fe);
    add("ill_d", 6'h3f, 6'h00, 1'b1, e(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1));
    add("badfn_f", 6'h00, 6'h00, 1'b0, fe);
    add("badfn_d", 6'h00, 6'h00, 1'b0, e(3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1));
    add("post_ill_f", 6'h00, 6'h21, 1'b0, fe);
    add("post_ill_d", 6'h00, 6'h21, 1'b0, dc);

    // initial reset
    reset = 1'b1; op = 6'h00; funct = 6'h00; zero = 1'b0;
    @(posedge clk); #1;
    chk("rst_init_0", zr);
    @(posedge clk); #1;
    chk("rst_init_1", zr);
    reset = 1'b0;
    #1;
    chk("rst_release_fetch", fe);

    foreach (vecs[i]) apply(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].exp);

    // finish the pending addu so the next reset test starts at FETCH
    apply("fin_addu_e", 6'h00, 6'h21, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0));
    apply("fin_addu_w", 6'h00, 6'h21, 1'b0, e(3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b1));

    // reset held 3 cycles while lw sits in MEM
    apply("rlw_f", 6'h23, 6'h00, 1'b0, fe);
    apply("rlw_d", 6'h23, 6'h00, 1'b0, dc);
    apply("rlw_e", 6'h23, 6'h00, 1'b0, e(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b01, 2'b00, 3'b000, 1'b0));
    reset = 1'b1;
    apply("rst_mem_c0", 6'h23, 6'h00, 1'b1, e(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0));
    apply("rst_mem_c1", 6'h23, 6'h00, 1'b1, zr);
    apply("rst_mem_c2", 6'h23, 6'h00, 1'b1, zr);
    reset = 1'b0;
    apply("rst_after_f", 6'h00, 6'h21, 1'b0, fe);
    apply("rst_after_d", 6'h00, 6'h21, 1'b0, dc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
